// File: rtl/reg_tree_param.sv
// Register fan-out tree: replicates one data word (plus valid) to NUM_OUT leaves through DEPTH stages.
// Define REG_TREE_PARAM_CE_EN to add the en (clock-enable / stall) input.
module reg_tree_param #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_OUT    = 4,
    parameter int FANOUT     = 4,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         in,
    input  logic                          in_valid,
`ifdef REG_TREE_PARAM_CE_EN
    input  logic                          en,
`endif
    output logic [NUM_OUT*DATA_WIDTH-1:0] out,
    output logic [NUM_OUT-1:0]            out_valid,
    output logic                          primed
);

    // Number of register nodes in stage s.
    function automatic int nodes_at(input int s);
        int n;
        n = 1;
        for (int i = 1; i <= s; i++) begin
            n = (n * FANOUT > NUM_OUT) ? NUM_OUT : n * FANOUT;
        end
        return n;
    endfunction

    // Index of the first node of stage s in the flattened node arrays.
    function automatic int offset_of(input int s);
        int o;
        o = 0;
        for (int i = 0; i < s; i++) begin
            o += nodes_at(i);
        end
        return o;
    endfunction

    function automatic int min_depth();
        int d;
        int n;
        d = 1;
        n = 1;
        while (n < NUM_OUT) begin
            n = n * FANOUT;
            d++;
        end
        return d;
    endfunction

    localparam int TOTAL    = offset_of(DEPTH);
    localparam int LAST_OFF = offset_of(DEPTH - 1);
    localparam int CNT_W    = $clog2(DEPTH + 1);

    if (NUM_OUT < 1 || FANOUT < 2 || DEPTH < min_depth()) begin : g_bad_shape
        $error("reg_tree_param: illegal shape NUM_OUT=%0d FANOUT=%0d DEPTH=%0d (min DEPTH %0d)",
               NUM_OUT, FANOUT, DEPTH, min_depth());
    end

    logic adv;
`ifdef REG_TREE_PARAM_CE_EN
    assign adv = en;
`else
    assign adv = 1'b1;
`endif

    logic [DATA_WIDTH-1:0] node_data  [TOTAL];
    logic                  node_valid [TOTAL];

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        localparam int N   = nodes_at(s);
        localparam int OFF = offset_of(s);
        for (genvar j = 0; j < N; j++) begin : g_node
            if (s == 0) begin : g_root
                // NOTE: non-blocking so every stage samples its parent's pre-edge value.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        node_data[0]  <= '0;
                        node_valid[0] <= 1'b0;
                    end else if (adv) begin
                        node_data[0]  <= in;
                        node_valid[0] <= in_valid;
                    end
                end
            end else begin : g_child
                // Balanced split: child j of N takes parent floor(j*PN/N).
                localparam int PN  = nodes_at(s - 1);
                localparam int PAR = offset_of(s - 1) + (j * PN) / N;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        node_data[OFF+j]  <= '0;
                        node_valid[OFF+j] <= 1'b0;
                    end else if (adv) begin
                        node_data[OFF+j]  <= node_data[PAR];
                        node_valid[OFF+j] <= node_valid[PAR];
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_leaf
        assign out[k*DATA_WIDTH +: DATA_WIDTH] = node_data[LAST_OFF+k];
        assign out_valid[k]                    = node_valid[LAST_OFF+k];
    end

    // Fill counter saturates at DEPTH, so primed is sticky until reset.
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            primed <= 1'b0;
        end else if (adv && count != CNT_W'(DEPTH)) begin
            count  <= count + 1'b1;
            primed <= (count == CNT_W'(DEPTH - 1));
        end
    end

endmodule

// File: tb/tb_reg_tree_param.sv
// Directed self-checking bench for reg_tree_param: default shape plus a 10-leaf FANOUT=3 instance.
module tb_reg_tree_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;

    logic [15:0] in_a = '0;
    logic        vin_a = 1'b0;
    logic [63:0] out_a;
    logic [3:0]  ov_a;
    logic        primed_a;

    logic [7:0]  in_b = '0;
    logic        vin_b = 1'b0;
    logic [79:0] out_b;
    logic [9:0]  ov_b;
    logic        primed_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_tree_param #(.DATA_WIDTH(16), .NUM_OUT(4), .FANOUT(4), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .in(in_a), .in_valid(vin_a),
`ifdef REG_TREE_PARAM_CE_EN
        .en(en),
`endif
        .out(out_a), .out_valid(ov_a), .primed(primed_a)
    );

    reg_tree_param #(.DATA_WIDTH(8), .NUM_OUT(10), .FANOUT(3), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .in(in_b), .in_valid(vin_b),
`ifdef REG_TREE_PARAM_CE_EN
        .en(en),
`endif
        .out(out_b), .out_valid(ov_b), .primed(primed_b)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_reset();
        rst   = 1'b1;
        en    = 1'b1;
        in_a  = '0;
        vin_a = 1'b0;
        in_b  = '0;
        vin_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_a !== 64'h0 || ov_a !== 4'b0 || primed_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: out=%h valid=%b primed=%b, want 0/0/0", out_a, ov_a, primed_a);
        end
        n_checks++;
        if (out_b !== 80'h0 || ov_b !== 10'h0 || primed_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: out=%h valid=%b primed=%b, want 0/0/0", out_b, ov_b, primed_b);
        end
    endtask

    task automatic test_single_word();
        do_reset();
        in_a  = 16'h1234;
        vin_a = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            in_a  = '0;
            vin_a = 1'b0;
            if (e == 3) begin
                n_checks++;
                if (ov_a !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL single_early: valid=%b at edge 3, want 0000", ov_a);
                end
            end
            if (e == 4) begin
                n_checks++;
                if (out_a !== {4{16'h1234}} || ov_a !== 4'b1111) begin
                    n_fail++;
                    $display("FAIL single_word: out=%h valid=%b, want %h/1111", out_a, ov_a, {4{16'h1234}});
                end
            end
            if (e == 5) begin
                n_checks++;
                if (ov_a !== 4'b0000 || out_a !== 64'h0) begin
                    n_fail++;
                    $display("FAIL single_after: out=%h valid=%b, want 0/0000", out_a, ov_a);
                end
            end
        end
    endtask

    task automatic test_priming();
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            n_checks++;
            if (primed_a !== (e >= 4)) begin
                n_fail++;
                $display("FAIL primed_edge%0d: primed=%b, want %b", e, primed_a, (e >= 4));
            end
        end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            in_a  = 16'(e);
            vin_a = 1'b1;
            @(negedge clk);
            if (e >= 4) begin
                n_checks++;
                if (out_a !== {4{16'(e - 3)}} || ov_a !== 4'b1111) begin
                    n_fail++;
                    $display("FAIL stream_edge%0d: out=%h valid=%b, want %h/1111",
                             e, out_a, ov_a, {4{16'(e - 3)}});
                end
            end
        end
        vin_a = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            in_a  = 16'(e);
            vin_a = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (out_a !== {4{16'h0005}} || primed_a !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: out=%h primed=%b, want %h/1", out_a, primed_a, {4{16'h0005}});
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_a !== 64'h0 || ov_a !== 4'b0 || primed_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: out=%h valid=%b primed=%b, want 0/0/0", out_a, ov_a, primed_a);
        end
        @(negedge clk);
        rst   = 1'b0;
        in_a  = 16'h0077;
        vin_a = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            in_a  = '0;
            vin_a = 1'b0;
            if (e == 3) begin
                n_checks++;
                if (ov_a !== 4'b0000 || out_a !== 64'h0) begin
                    n_fail++;
                    $display("FAIL post_reset_early: out=%h valid=%b, want 0/0000", out_a, ov_a);
                end
            end
            if (e == 4) begin
                n_checks++;
                if (out_a !== {4{16'h0077}} || ov_a !== 4'b1111 || primed_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL post_reset_word: out=%h valid=%b primed=%b, want %h/1111/1",
                             out_a, ov_a, primed_a, {4{16'h0077}});
                end
            end
        end
    endtask

    task automatic test_wide_tree();
        do_reset();
        in_b  = 8'hA5;
        vin_b = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            in_b  = '0;
            vin_b = 1'b0;
            if (e == 3) begin
                n_checks++;
                if (ov_b !== 10'h000) begin
                    n_fail++;
                    $display("FAIL wide_early: valid=%b, want 0", ov_b);
                end
            end
            if (e == 4) begin
                n_checks++;
                if (out_b !== {10{8'hA5}} || ov_b !== 10'h3FF) begin
                    n_fail++;
                    $display("FAIL wide_word: out=%h valid=%b, want %h/3ff", out_b, ov_b, {10{8'hA5}});
                end
            end
            if (e == 5) begin
                n_checks++;
                if (out_b !== 80'h0 || ov_b !== 10'h000) begin
                    n_fail++;
                    $display("FAIL wide_after: out=%h valid=%b, want 0/0", out_b, ov_b);
                end
            end
        end
    endtask

`ifdef REG_TREE_PARAM_CE_EN
    task automatic test_stall();
        do_reset();
        in_a  = 16'h00FF;
        vin_a = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            in_a  = '0;
            vin_a = 1'b0;
            // en-high edges are 1,2,6,7; edges 3-5 and 8-9 are stalls.
            en = !((e >= 2 && e <= 4) || (e >= 7 && e <= 8));
            if (e >= 3 && e <= 6) begin
                n_checks++;
                if (ov_a !== 4'b0000 || primed_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_edge%0d: valid=%b primed=%b, want 0000/0", e, ov_a, primed_a);
                end
            end
            if (e >= 7 && e <= 9) begin
                n_checks++;
                if (out_a !== {4{16'h00FF}} || ov_a !== 4'b1111 || primed_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_out_edge%0d: out=%h valid=%b primed=%b, want %h/1111/1",
                             e, out_a, ov_a, primed_a, {4{16'h00FF}});
                end
            end
            if (e == 10) begin
                n_checks++;
                if (ov_a !== 4'b0000 || primed_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_resume: valid=%b primed=%b, want 0000/1", ov_a, primed_a);
                end
            end
        end
        en = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_priming();
        test_streaming();
        test_async_reset();
        test_wide_tree();
`ifdef REG_TREE_PARAM_CE_EN
        test_stall();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
